// File: rtl/nibble_deserializer.sv
// nibble_deserializer: serial-to-parallel word assembler with a 2-entry
// first-word-fall-through output FIFO, frame resync on sof, and optional
// per-word even parity.
// Optional feature macro: PARITY_EN (adds one even-parity slot after each word).

module nibble_deserializer #(
   parameter int unsigned DATA_W    = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_valid,
   input  logic              bit_in,
   input  logic              sof,
   output logic              bit_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              frame_err,
   output logic              parity_err
);

`ifdef PARITY_EN
   localparam int unsigned Slots = DATA_W + 1;
`else
   localparam int unsigned Slots = DATA_W;
`endif
   localparam int unsigned CntW = $clog2(Slots + 1);

   // Assembly state
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              frame_err_q, frame_err_d;
   logic              parity_err_q, parity_err_d;

   // FIFO state
   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        occ_q, occ_d;

   logic              accept;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] push_word;
   logic [DATA_W-1:0] shifted;
   logic [CntW-1:0]   idx;

   assign bit_ready  = (occ_q != 2'd2);
   assign data_valid = (occ_q != 2'd0);
   assign data_out   = mem_q[rd_ptr_q];
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;

   assign accept = bit_valid && bit_ready;
   assign pop    = data_valid && data_ready;

   // Bit assembly: shift, count slots, detect word completion and framing errors
   always_comb begin
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      push         = 1'b0;
      // sof forces this bit to be slot 0 of a fresh word
      idx          = sof ? '0 : cnt_q;
      if (MSB_FIRST) begin
         shifted = {shift_q[DATA_W-2:0], bit_in};
      end else begin
         shifted = {bit_in, shift_q[DATA_W-1:1]};
      end
      push_word = shifted;

      if (accept) begin
         if (sof && (cnt_q != '0)) begin
            frame_err_d = 1'b1;
         end
         if (idx == CntW'(Slots - 1)) begin
            cnt_d = '0;
`ifdef PARITY_EN
            // Parity slot: shift_q already holds exactly the data bits
            if (((^shift_q) ^ bit_in) != 1'b0) begin
               parity_err_d = 1'b1;
            end else begin
               push      = 1'b1;
               push_word = shift_q;
            end
`else
            push    = 1'b1;
            shift_d = shifted;
`endif
         end else begin
            cnt_d   = idx + CntW'(1);
            shift_d = shifted;
         end
      end
   end

   // FIFO next state: registered push, fall-through head, mod-2 pointers
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_word;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q      <= '0;
         cnt_q        <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         mem_q[0]     <= '0;
         mem_q[1]     <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         occ_q        <= 2'd0;
      end else begin
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
      end
   end

endmodule

// File: tb/tb_nibble_deserializer.sv
// Bench for nibble_deserializer: two instances (MSB-first and LSB-first) share
// stimulus; a queue-based word model predicts every output each cycle.

module tb_nibble_deserializer;

   localparam int W = 4;
`ifdef PARITY_EN
   localparam int SLOTS = W + 1;
   localparam bit PAR   = 1'b1;
`else
   localparam int SLOTS = W;
   localparam bit PAR   = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic bit_valid, bit_in, sof, data_ready;
   logic bit_ready_m, data_valid_m, frame_err_m, parity_err_m;
   logic bit_ready_l, data_valid_l, frame_err_l, parity_err_l;
   logic [W-1:0] data_out_m, data_out_l;

   nibble_deserializer #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_m (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .sof        (sof),
      .bit_ready  (bit_ready_m),
      .data_out   (data_out_m),
      .data_valid (data_valid_m),
      .data_ready (data_ready),
      .frame_err  (frame_err_m),
      .parity_err (parity_err_m)
   );

   nibble_deserializer #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_l (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .sof        (sof),
      .bit_ready  (bit_ready_l),
      .data_out   (data_out_l),
      .data_valid (data_valid_l),
      .data_ready (data_ready),
      .frame_err  (frame_err_l),
      .parity_err (parity_err_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: bits of the word in progress, and expected FIFO contents
   bit          cb[$];
   logic [15:0] fq_m[$];
   logic [15:0] fq_l[$];
   logic        exp_fe = 1'b0;
   logic        exp_pe = 1'b0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle at posedge+1, check all outputs before the next edge,
   // advance the model, and return whether the bit was accepted.
   task automatic cycle(input logic bv, input logic bi, input logic s, input logic dr,
                        output logic acc);
      logic        pop;
      logic        push;
      logic [15:0] wm;
      logic [15:0] wl;
      bit          par;
      bit_valid  = bv;
      bit_in     = bi;
      sof        = s;
      data_ready = dr;
      #3;
      chk("bit_ready_m", 16'(bit_ready_m), 16'(fq_m.size() < 2));
      chk("bit_ready_l", 16'(bit_ready_l), 16'(fq_l.size() < 2));
      chk("data_valid_m", 16'(data_valid_m), 16'(fq_m.size() > 0));
      chk("data_valid_l", 16'(data_valid_l), 16'(fq_l.size() > 0));
      if (fq_m.size() > 0) chk("data_out_m", 16'(data_out_m), fq_m[0]);
      if (fq_l.size() > 0) chk("data_out_l", 16'(data_out_l), fq_l[0]);
      chk("frame_err_m", 16'(frame_err_m), 16'(exp_fe));
      chk("frame_err_l", 16'(frame_err_l), 16'(exp_fe));
      chk("parity_err_m", 16'(parity_err_m), 16'(exp_pe));
      chk("parity_err_l", 16'(parity_err_l), 16'(exp_pe));

      acc    = bv && (fq_m.size() < 2);
      pop    = (fq_m.size() > 0) && dr;
      push   = 1'b0;
      exp_fe = 1'b0;
      exp_pe = 1'b0;
      wm     = '0;
      wl     = '0;
      if (acc) begin
         if (s) begin
            if (cb.size() != 0) exp_fe = 1'b1;
            cb.delete();
         end
         cb.push_back(bi);
         if (cb.size() == SLOTS) begin
            par = 1'b0;
            for (int i = 0; i < W; i++) begin
               wm = wm + (16'(cb[i]) << (W - 1 - i));
               wl = wl + (16'(cb[i]) << i);
            end
            for (int i = 0; i < SLOTS; i++) par = par ^ cb[i];
            if (PAR && par) exp_pe = 1'b1;
            else push = 1'b1;
            cb.delete();
         end
      end
      if (pop) begin
         void'(fq_m.pop_front());
         void'(fq_l.pop_front());
      end
      if (push) begin
         fq_m.push_back(wm);
         fq_l.push_back(wl);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic bi, input logic s, input logic dr);
      logic acc;
      acc = 1'b0;
      for (int k = 0; k < 16 && !acc; k++) cycle(1'b1, bi, s, dr, acc);
      n_vec++;
      assert (acc)
      else begin
         n_err++;
         $error("FAIL accept_timeout: observed 0 expected 1");
      end
   endtask

   // Send a word MSB of the value first, plus its even-parity bit when enabled
   task automatic send_word(input logic [W-1:0] v, input logic sof_first, input logic dr);
      for (int i = W - 1; i >= 0; i--) send_bit(v[i], (i == W - 1) ? sof_first : 1'b0, dr);
      if (PAR) send_bit(^v, 1'b0, dr);
   endtask

   task automatic idle(input int n, input logic dr);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, dr, acc);
   endtask

   task automatic do_reset(input int n);
      rst_n      = 1'b0;
      bit_valid  = 1'b0;
      bit_in     = 1'b0;
      sof        = 1'b0;
      data_ready = 1'b0;
      cb.delete();
      fq_m.delete();
      fq_l.delete();
      exp_fe = 1'b0;
      exp_pe = 1'b0;
      for (int i = 0; i < n; i++) begin
         #3;
         chk("rst_bit_ready", 16'(bit_ready_m), 16'd1);
         chk("rst_data_valid", 16'(data_valid_m), 16'd0);
         chk("rst_data_out", 16'(data_out_m), 16'd0);
         chk("rst_data_out_l", 16'(data_out_l), 16'd0);
         chk("rst_frame_err", 16'(frame_err_m), 16'd0);
         chk("rst_parity_err", 16'(parity_err_m), 16'd0);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      logic acc;
      rst_n      = 1'b1;
      bit_valid  = 1'b0;
      bit_in     = 1'b0;
      sof        = 1'b0;
      data_ready = 1'b0;
      #1;
      do_reset(2);

      // 1011 -> 0xB MSB-first, 0xD LSB-first, valid for exactly one cycle
      send_word(4'hB, 1'b0, 1'b1);
      chk("plan_msb_word", 16'(data_out_m), 16'hB);
      chk("plan_lsb_word", 16'(data_out_l), 16'hD);
      chk("plan_valid_rise", 16'(data_valid_m), 16'd1);
      idle(1, 1'b1);
      chk("plan_valid_one_cycle", 16'(data_valid_m), 16'd0);
      idle(2, 1'b1);

      // Backpressure: two words fill the FIFO, third stalls until drained
      send_word(4'hB, 1'b0, 1'b0);
      send_word(4'h5, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, acc);
      chk("stall_bit_ready", 16'(bit_ready_m), 16'd0);
      chk("stall_head", 16'(data_out_m), 16'hB);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, acc);
      send_word(4'h3, 1'b0, 1'b1);
      idle(4, 1'b1);

      // Partial word 1,0 discarded by sof; resynced word 0110
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b0, 1'b0, 1'b1);
      send_bit(1'b0, 1'b1, 1'b1);
      chk("sof_frame_err", 16'(frame_err_m), 16'd1);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b1, 1'b0, 1'b1);
      send_word(4'h6, 1'b1, 1'b1);
      idle(3, 1'b1);

      // Reset mid-word discards the partial bits without frame_err
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b1, 1'b0, 1'b1);
      do_reset(2);
      send_word(4'h7, 1'b0, 1'b1);
      chk("rst_mid_word", 16'(data_out_m), 16'h7);
      idle(2, 1'b1);

`ifdef PARITY_EN
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b0, 1'b0, 1'b1);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b1, 1'b0, 1'b1);
      chk("par_good_word", 16'(data_out_m), 16'hB);
      idle(2, 1'b1);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b0, 1'b0, 1'b1);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b0, 1'b0, 1'b1);
      chk("par_bad_pulse", 16'(parity_err_m), 16'd1);
      chk("par_bad_no_valid", 16'(data_valid_m), 16'd0);
      idle(2, 1'b1);
`endif

      // Randomised traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset(1);
         end else begin
            cycle(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 9) < 6), acc);
         end
      end
      idle(4, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
